// File: rtl/avmm_mc_wr_ack_router.sv
`default_nettype none
// ============================================================================
// Module      : avmm_mc_wr_ack_router
// Description : Routes in-order EMIF write acks back to the kernel channel
//               that issued each write burst. Start-of-burst beats are
//               recorded in an in-order tracking queue as {ch_id, burstcnt};
//               every EMIF write ack pops the queue head and pulses the
//               matching channel's ack one cycle later.
// Ports       :
//   kernel_avmm_clk / kernel_avmm_reset : clock, sync active-high reset
//   emif_avmm_wr/_waitreq/_burstcnt/_ch_id : post-mux EMIF write beat
//   emif_avmm_wr_ack      : in-order burst completion pulse from EMIF
//   ch_wr_ack             : per-channel one-hot ack pulse
//   ch_wr_ack_burstcnt    : burstcount of the acked burst (held between acks)
//   ch_pending / ch_idle  : per-channel outstanding burst count / idle flag
//   track_almost_full     : backpressure to the mux
//   err_overflow/_underflow/_bad_ch : sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module avmm_mc_wr_ack_router #(
  parameter int NUM_CH                = 4,
  parameter int AVMM_BURSTCNT_WIDTH   = 7,
  parameter int TRACK_DEPTH           = 64,
  parameter int ALMOST_FULL_THRESHOLD = 8,
  parameter int CH_ID_W               = ($clog2(NUM_CH) < 1) ? 1 : $clog2(NUM_CH)
) (
  input  logic                                          kernel_avmm_clk,
  input  logic                                          kernel_avmm_reset,
  input  logic                                          emif_avmm_wr,
  input  logic                                          emif_avmm_waitreq,
  input  logic [AVMM_BURSTCNT_WIDTH-1:0]                emif_avmm_burstcnt,
  input  logic [CH_ID_W-1:0]                            emif_avmm_ch_id,
  input  logic                                          emif_avmm_wr_ack,
  output logic [NUM_CH-1:0]                             ch_wr_ack,
  output logic [AVMM_BURSTCNT_WIDTH-1:0]                ch_wr_ack_burstcnt,
  output logic [NUM_CH*$clog2(TRACK_DEPTH+1)-1:0]       ch_pending,
  output logic [NUM_CH-1:0]                             ch_idle,
  output logic                                          track_almost_full,
  output logic                                          err_overflow,
  output logic                                          err_underflow,
  output logic                                          err_bad_ch
);

  localparam int PTR_W  = $clog2(TRACK_DEPTH);
  localparam int OCC_W  = PTR_W + 1;
  localparam int PEND_W = $clog2(TRACK_DEPTH + 1);
  localparam int BC_W   = AVMM_BURSTCNT_WIDTH;
  localparam int ENT_W  = CH_ID_W + BC_W;

  localparam logic [31:0]       NUM_CH_U = NUM_CH;
  localparam logic [31:0]       DEPTH_U  = TRACK_DEPTH;
  localparam logic [31:0]       THR_U    = ALMOST_FULL_THRESHOLD;
  localparam logic [OCC_W-1:0]  OCC_FULL = OCC_W'(TRACK_DEPTH);

  wire clk = kernel_avmm_clk;
  wire rst = kernel_avmm_reset;

  // --------------------------------------------------------------------------
  // Burst framing FSM: only its IDLE state identifies start-of-burst beats.
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t            state_q;
  logic [BC_W-1:0]   beat_cnt_q;

  logic              accept;
  logic              sob;

  assign accept = emif_avmm_wr & ~emif_avmm_waitreq & ~rst;
  assign sob    = accept & (state_q == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      beat_cnt_q <= '0;
    end else if (accept) begin
      case (state_q)
        S_IDLE: begin
          // burstcnt of 0 is framed as a single beat
          beat_cnt_q <= (emif_avmm_burstcnt == '0) ? '0
                                                   : emif_avmm_burstcnt - BC_W'(1);
          state_q    <= (emif_avmm_burstcnt > BC_W'(1)) ? S_BURST : S_IDLE;
        end
        S_BURST: begin
          beat_cnt_q <= beat_cnt_q - BC_W'(1);
          if (beat_cnt_q == BC_W'(1)) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          beat_cnt_q <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // In-order tracking queue
  // --------------------------------------------------------------------------
  logic [ENT_W-1:0]  mem_q [TRACK_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [OCC_W-1:0]  occ_q;
  logic [OCC_W-1:0]  occ_d;

  logic              ch_legal;
  logic              full;
  logic              empty;
  logic              pop;
  logic              enq;
  logic [ENT_W-1:0]  head;
  logic [CH_ID_W-1:0] head_ch;
  logic [BC_W-1:0]   head_bc;
  logic [31:0]       free_d;
  logic [NUM_CH-1:0] ack_d;

  assign ch_legal = 32'(emif_avmm_ch_id) < NUM_CH_U;
  assign full     = (occ_q == OCC_FULL);
  assign empty    = (occ_q == '0);
  // The head is only valid from the cycle after its enqueue, so an ack in
  // the enqueue cycle of the first entry sees an empty queue.
  assign pop      = emif_avmm_wr_ack & ~empty & ~rst;
  // A simultaneous pop frees a slot, so a full queue can still accept.
  assign enq      = sob & ch_legal & (~full | pop);

  assign head     = mem_q[rd_ptr_q];
  assign head_ch  = head[ENT_W-1:BC_W];
  assign head_bc  = head[BC_W-1:0];

  assign occ_d    = occ_q + {{(OCC_W-1){1'b0}}, enq} - {{(OCC_W-1){1'b0}}, pop};
  assign free_d   = DEPTH_U - 32'(occ_d);

  // Storage has no reset so it can map onto RAM; pointers define validity.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[wr_ptr_q] <= {emif_avmm_ch_id, emif_avmm_burstcnt};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q           <= '0;
      rd_ptr_q           <= '0;
      occ_q              <= '0;
      ch_wr_ack          <= '0;
      ch_wr_ack_burstcnt <= '0;
      track_almost_full  <= 1'b0;
      err_overflow       <= 1'b0;
      err_underflow      <= 1'b0;
      err_bad_ch         <= 1'b0;
    end else begin
      if (enq) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q           <= rd_ptr_q + PTR_W'(1);
        ch_wr_ack_burstcnt <= head_bc;
      end
      occ_q             <= occ_d;
      ch_wr_ack         <= ack_d;
      track_almost_full <= (free_d <= THR_U);
      if (sob & ~ch_legal) begin
        err_bad_ch <= 1'b1;
      end
      if (sob & ch_legal & full & ~pop) begin
        err_overflow <= 1'b1;
      end
      if (emif_avmm_wr_ack & empty) begin
        err_underflow <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel outstanding counters and ack decode
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      localparam logic [CH_ID_W-1:0] C_ID     = CH_ID_W'(i);
      localparam logic [PEND_W-1:0]  PEND_MAX = PEND_W'(TRACK_DEPTH);

      logic              inc;
      logic              dec;
      logic [PEND_W-1:0] pend_q;
      logic [PEND_W-1:0] pend_d;
      logic              idle_q;

      assign inc      = enq & (emif_avmm_ch_id == C_ID);
      assign dec      = pop & (head_ch == C_ID);
      assign ack_d[i] = dec;

      // Saturating at both ends; inc and dec together cancel.
      always_comb begin
        pend_d = pend_q;
        if (inc & ~dec & (pend_q != PEND_MAX)) begin
          pend_d = pend_q + PEND_W'(1);
        end else if (dec & ~inc & (pend_q != '0)) begin
          pend_d = pend_q - PEND_W'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          pend_q <= '0;
          idle_q <= 1'b1;
        end else begin
          pend_q <= pend_d;
          idle_q <= (pend_d == '0);
        end
      end

      assign ch_pending[i*PEND_W +: PEND_W] = pend_q;
      assign ch_idle[i]                     = idle_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_avmm_mc_wr_ack_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_avmm_mc_wr_ack_router
// Description : Self-checking bench for avmm_mc_wr_ack_router. A queue-based
//               reference model tracks issued bursts, per-channel pending
//               counts and sticky error flags; every cycle the DUT outputs
//               are compared against it, with directed scenarios followed
//               by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avmm_mc_wr_ack_router;

  localparam int NCH   = 4;
  localparam int DEPTH = 64;
  localparam int THR   = 8;
  localparam int PW    = 7;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr  = 1'b0;
  logic              wq  = 1'b0;
  logic [6:0]        bc  = '0;
  logic [2:0]        ch  = '0;
  logic              ack = 1'b0;
  logic [NCH-1:0]    o_ack;
  logic [6:0]        o_bc;
  logic [NCH*PW-1:0] o_pend;
  logic [NCH-1:0]    o_idle;
  logic              o_af;
  logic              o_ov;
  logic              o_un;
  logic              o_bad;

  always #5 clk = ~clk;

  avmm_mc_wr_ack_router #(
    .NUM_CH(NCH),
    .AVMM_BURSTCNT_WIDTH(7),
    .TRACK_DEPTH(DEPTH),
    .ALMOST_FULL_THRESHOLD(THR),
    .CH_ID_W(3)
  ) dut (
    .kernel_avmm_clk(clk),
    .kernel_avmm_reset(rst),
    .emif_avmm_wr(wr),
    .emif_avmm_waitreq(wq),
    .emif_avmm_burstcnt(bc),
    .emif_avmm_ch_id(ch),
    .emif_avmm_wr_ack(ack),
    .ch_wr_ack(o_ack),
    .ch_wr_ack_burstcnt(o_bc),
    .ch_pending(o_pend),
    .ch_idle(o_idle),
    .track_almost_full(o_af),
    .err_overflow(o_ov),
    .err_underflow(o_un),
    .err_bad_ch(o_bad)
  );

  // ---------------- reference model ----------------
  typedef struct { int c; int b; } ent_t;
  ent_t q[$];
  int   pend[NCH];
  bit   m_ov, m_un, m_bad;
  logic [NCH-1:0] exp_ack;
  logic [6:0]     exp_bc;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [NCH*PW-1:0] ep;
    logic [NCH-1:0]    ei;
    for (int i = 0; i < NCH; i++) begin
      ep[i*PW +: PW] = 7'(pend[i]);
      ei[i]          = (pend[i] == 0);
    end
    chk("ch_wr_ack",     32'(o_ack),  32'(exp_ack));
    chk("ack_burstcnt",  32'(o_bc),   32'(exp_bc));
    chk("ch_pending",    32'(o_pend), 32'(ep));
    chk("ch_idle",       32'(o_idle), 32'(ei));
    chk("almost_full",   32'(o_af),   32'((DEPTH - q.size()) <= THR));
    chk("err_overflow",  32'(o_ov),   32'(m_ov));
    chk("err_underflow", 32'(o_un),   32'(m_un));
    chk("err_bad_ch",    32'(o_bad),  32'(m_bad));
  endtask

  // One clock: drive inputs, advance model, clock, compare.
  // i_sob marks the first beat of a burst as issued by the driver.
  task automatic tick(input bit i_wr, input bit i_wq, input int i_bc,
                      input int i_ch, input bit i_ack, input bit i_sob);
    bit   do_pop;
    bit   was_full;
    ent_t h;
    wr  = i_wr;
    wq  = i_wq;
    bc  = 7'(i_bc);
    ch  = 3'(i_ch);
    ack = i_ack;
    if (rst) begin
      q.delete();
      for (int i = 0; i < NCH; i++) pend[i] = 0;
      m_ov = 0; m_un = 0; m_bad = 0;
      exp_ack = '0;
      exp_bc  = '0;
    end else begin
      do_pop   = i_ack && (q.size() > 0);
      was_full = (q.size() == DEPTH);
      exp_ack  = '0;
      if (i_ack && q.size() == 0) m_un = 1;
      if (do_pop) begin
        h = q.pop_front();
        exp_ack = 4'(1 << h.c);
        exp_bc  = 7'(h.b);
        pend[h.c]--;
      end
      if (i_wr && !i_wq && i_sob) begin
        if (i_ch >= NCH) m_bad = 1;
        else if (was_full && !do_pop) m_ov = 1;
        else begin
          q.push_back('{c: i_ch, b: i_bc});
          pend[i_ch]++;
        end
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    // Active traffic during reset must be ignored.
    tick(1'b1, 1'b0, 3, 1, 1'b1, 1'b1);
    rst = 1'b0;
  endtask

  task automatic send_burst(input int c, input int b, input int p_stall, input int p_ack);
    int  n;
    int  done;
    bit  first;
    bit  st;
    bit  a;
    n     = (b == 0) ? 1 : b;
    done  = 0;
    first = 1;
    while (done < n) begin
      st = ($urandom_range(99) < p_stall);
      a  = ($urandom_range(99) < p_ack);
      if (first) tick(1'b1, st, b, c, a, 1'b1);
      else       tick(1'b1, st, int'($urandom_range(127)), int'($urandom_range(7)), a, 1'b0);
      if (!st) begin
        done++;
        first = 0;
      end
    end
  endtask

  task automatic idle(input int n, input int p_ack);
    for (int k = 0; k < n; k++) begin
      tick(1'b0, 1'($urandom_range(1)), int'($urandom_range(127)),
           int'($urandom_range(7)), 1'($urandom_range(99) < p_ack), 1'b0);
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() > 0 && guard < 300) begin
      tick(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
      guard++;
    end
    chk("drain_done", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    do_reset();
    chk("reset_idle", 32'(o_idle), 32'hf);

    // Single beat to channel 2, ack five cycles later
    tick(1'b1, 1'b0, 1, 2, 1'b0, 1'b1);
    chk("single_pend2", 32'(o_pend[2*PW +: PW]), 32'd1);
    idle(4, 0);
    tick(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
    chk("single_ack", 32'(o_ack), 32'b0100);
    chk("single_bc", 32'(o_bc), 32'd1);
    tick(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("single_pulse_end", 32'(o_ack), 32'd0);
    chk("single_bc_hold", 32'(o_bc), 32'd1);

    // Stalled burst ch1 x4 with alternating waitreq; ch_id changes mid-burst
    tick(1'b1, 1'b1, 4, 1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 4, 1, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 9, 1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 9, 1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 2, 3, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 2, 3, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 5, 0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 5, 0, 1'b0, 1'b0);
    send_burst(3, 2, 0, 0);
    tick(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
    chk("stall_ack1", 32'(o_ack), 32'b0010);
    chk("stall_bc1", 32'(o_bc), 32'd4);
    tick(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
    chk("stall_ack2", 32'(o_ack), 32'b1000);
    chk("stall_bc2", 32'(o_bc), 32'd2);

    // Fill to full, simultaneous SOB+ack at full, then overflow, then drain
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      tick(1'b1, 1'b0, 1, k % NCH, 1'b0, 1'b1);
      chk("fill_af", 32'(o_af), 32'(k + 1 >= DEPTH - THR));
    end
    tick(1'b1, 1'b0, 1, 2, 1'b1, 1'b1);
    chk("full_simul_no_ov", 32'(o_ov), 32'd0);
    chk("full_simul_ack", 32'(o_ack), 32'b0001);
    tick(1'b1, 1'b0, 1, 3, 1'b0, 1'b1);
    chk("full_overflow", 32'(o_ov), 32'd1);
    drain();

    // Error cases: ack while empty, bad channel, ack during first enqueue
    do_reset();
    tick(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
    chk("underflow_flag", 32'(o_un), 32'd1);
    chk("underflow_no_ack", 32'(o_ack), 32'd0);
    tick(1'b1, 1'b0, 1, 5, 1'b0, 1'b1);
    chk("bad_ch_flag", 32'(o_bad), 32'd1);
    chk("bad_ch_pend", 32'(o_pend), 32'd0);
    do_reset();
    tick(1'b1, 1'b0, 1, 0, 1'b1, 1'b1);
    chk("first_enq_underflow", 32'(o_un), 32'd1);
    chk("first_enq_no_ack", 32'(o_ack), 32'd0);
    drain();

    // burstcnt 0 frames as a single beat: next beat is a new SOB
    do_reset();
    tick(1'b1, 1'b0, 0, 1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1, 2, 1'b0, 1'b1);
    chk("bc0_pend2", 32'(o_pend[2*PW +: PW]), 32'd1);
    drain();

    // Reset mid-burst with bursts outstanding
    do_reset();
    send_burst(0, 1, 0, 0);
    send_burst(1, 1, 0, 0);
    send_burst(2, 1, 0, 0);
    tick(1'b1, 1'b0, 8, 3, 1'b0, 1'b1);
    rst = 1'b1;
    tick(1'b1, 1'b0, 8, 3, 1'b0, 1'b0);
    rst = 1'b0;
    chk("midrst_idle", 32'(o_idle), 32'hf);
    tick(1'b1, 1'b0, 1, 2, 1'b0, 1'b1);
    chk("midrst_sob_pend2", 32'(o_pend[2*PW +: PW]), 32'd1);
    drain();

    // Randomized traffic: heavy-issue phase then heavy-ack phase
    do_reset();
    for (int it = 0; it < 250; it++) begin
      send_burst(($urandom_range(19) == 0) ? int'($urandom_range(7, 4)) : int'($urandom_range(3)),
                 int'($urandom_range(6)), 30, 12);
      if ($urandom_range(3) == 0) idle(int'($urandom_range(3)), 20);
    end
    for (int it = 0; it < 250; it++) begin
      send_burst(int'($urandom_range(3)), int'($urandom_range(1, 5)), 25, 50);
      if ($urandom_range(2) == 0) idle(int'($urandom_range(4)), 60);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
